// File: rtl/toa_pkg.sv
// Shared types and defaults for the time-of-arrival capture block.
package toa_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  localparam int TW_DEF      = 16;
  localparam int CONFIRM_DEF = 2;
  localparam int TIMEOUT_DEF = 40000;
  localparam int FLT_W       = 3;

  // Bit offset of channel ch inside the packed timestamp bus.
  function automatic int ts_lsb(input int ch, input int tw);
    return ch * tw;
  endfunction

endpackage

// File: rtl/toa_confirm.sv
// One-channel debounce: det must stay high for CONFIRM consecutive enabled cycles.
module toa_confirm
  import toa_pkg::*;
#(
  parameter int CONFIRM = CONFIRM_DEF
) (
  input  logic clk8M,
  input  logic reset,
  input  logic i_en,
  input  logic i_det,
  input  logic i_hit,
  output logic o_confirm
);

  localparam logic [FLT_W-1:0] LP_MATCH = FLT_W'(CONFIRM - 1);

  logic [FLT_W-1:0] r_flt;

  // Saturating run length so a long-held det can never re-match after capture.
  always_ff @(posedge clk8M) begin
    if (reset || !i_en || !i_det) begin
      r_flt <= '0;
    end else if (r_flt != '1) begin
      r_flt <= r_flt + 1'b1;
    end
  end

  assign o_confirm = i_det & (r_flt == LP_MATCH) & ~i_hit;

endmodule

// File: rtl/toa_capture.sv
// Shot controller: arms on request, timestamps each channel's first confirmed hit
// relative to the earliest one, and ends on all-hit or timeout.
module toa_capture
  import toa_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int TW      = TW_DEF,
  parameter int CONFIRM = CONFIRM_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk8M,
  input  logic              reset,
  input  logic              i_arm,
  input  logic [NCH-1:0]    i_det,
  input  logic              i_rd_ack,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout,
  output logic [NCH-1:0]    o_hit,
  output logic [NCH*TW-1:0] o_ts
);

  localparam logic [TW-1:0] LP_TIMEOUT = TW'(TIMEOUT);

  state_t             r_state;
  logic [TW-1:0]      r_cnt;
  logic [NCH-1:0]     r_hit;
  logic [NCH*TW-1:0]  r_ts;
  logic               r_busy;
  logic               r_done;
  logic               r_timeout;

  logic               w_en;
  logic [NCH-1:0]     w_confirm;
  logic               w_any;
  logic               w_all_hit;

  assign w_en      = (r_state == ARMED) || (r_state == RUN);
  assign w_any     = |w_confirm;
  assign w_all_hit = &(r_hit | w_confirm);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    toa_confirm #(.CONFIRM(CONFIRM)) u_confirm (
      .clk8M    (clk8M),
      .reset    (reset),
      .i_en     (w_en),
      .i_det    (i_det[g]),
      .i_hit    (r_hit[g]),
      .o_confirm(w_confirm[g])
    );
  end

  // In ARMED r_cnt is still 0, so the same capture path gives the first hits ts=0.
  always_ff @(posedge clk8M) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hit     <= '0;
      r_ts      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_arm) begin
            r_state   <= ARMED;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_hit     <= '0;
            r_ts      <= '0;
            r_timeout <= 1'b0;
          end
        end
        ARMED: begin
          if (w_any) begin
            for (int i = 0; i < NCH; i++) begin
              if (w_confirm[i]) begin
                r_hit[i]                   <= 1'b1;
                r_ts[ts_lsb(i, TW) +: TW]  <= r_cnt;
              end
            end
            r_cnt <= r_cnt + 1'b1;
            if (w_all_hit) begin
              r_state   <= DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_timeout <= 1'b0;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          for (int i = 0; i < NCH; i++) begin
            if (w_confirm[i]) begin
              r_hit[i]                  <= 1'b1;
              r_ts[ts_lsb(i, TW) +: TW] <= r_cnt;
            end
          end
          r_cnt <= r_cnt + 1'b1;
          // A late capture on the timeout cycle still counts; all-hit takes priority.
          if (w_all_hit) begin
            r_state   <= DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b0;
          end else if (r_cnt == LP_TIMEOUT) begin
            r_state   <= DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        DONE: begin
          if (i_rd_ack) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_timeout = r_timeout;
  assign o_hit     = r_hit;
  assign o_ts      = r_ts;

endmodule
